// File: rtl/goldschmidt_ctrl.sv
// ============================================================================
// Module   : goldschmidt_ctrl
// Purpose  : Start/done sequencer for the Goldschmidt divide / square-root
//            datapath: operand-mux selects and N/D/K/QD register enables.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module goldschmidt_ctrl #(
  parameter int DIV_ITERS  = 5,
  parameter int SQRT_ITERS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       abort,
  output logic [1:0] op_q,
  output logic [1:0] sA,
  output logic [1:0] sB,
  output logic       selBA,
  output logic       enableN,
  output logic       enableD,
  output logic       enableK,
  output logic       enableQD,
  output logic       busy,
  output logic       done
);

  localparam int L_DIV  = 2 * DIV_ITERS + 2;
  localparam int L_SQRT = 3 * SQRT_ITERS + 4;
  localparam int L_MAX  = (L_DIV > L_SQRT) ? L_DIV : L_SQRT;
  localparam int CNT_W  = $clog2(L_MAX);

  localparam logic [CNT_W-1:0] C_ONE           = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO           = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_THREE         = CNT_W'(3);
  localparam logic [CNT_W-1:0] C_DIV_LOOP_END  = CNT_W'(2 * DIV_ITERS);
  localparam logic [CNT_W-1:0] C_DIV_LAST      = CNT_W'(L_DIV - 1);
  localparam logic [CNT_W-1:0] C_SQRT_LOOP_END = CNT_W'(3 * SQRT_ITERS + 2);
  localparam logic [CNT_W-1:0] C_SQRT_LAST     = CNT_W'(L_SQRT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_op;
  logic [1:0]       w_op_nxt;
  logic             w_is_div;
  logic [CNT_W-1:0] w_last;
  logic [CNT_W-1:0] w_rel;
  logic [CNT_W-1:0] w_phase;

  assign w_is_div = (r_op == 2'b00);
  assign w_last   = w_is_div ? C_DIV_LAST : C_SQRT_LAST;
  // Position inside the N / K(square) / DK triple of the sqrt refinement loop.
  assign w_rel    = r_cnt - C_THREE;
  assign w_phase  = w_rel % C_THREE;
  assign op_q     = r_op;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    sA          = 2'd0;
    sB          = 2'd0;
    selBA       = 1'b0;
    enableN     = 1'b0;
    enableD     = 1'b0;
    enableK     = 1'b0;
    enableQD    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!abort && start) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
          w_op_nxt    = op;
        end
      end

      S_RUN: begin
        busy = 1'b1;
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end

        if (w_is_div) begin
          if (r_cnt == '0) begin
            enableN = 1'b1;
          end else if (r_cnt == C_ONE) begin
            sB      = 2'd1;
            enableD = 1'b1;
            enableK = 1'b1;
          end else if (r_cnt <= C_DIV_LOOP_END) begin
            sA = 2'd1;
            if (!r_cnt[0]) begin
              sB      = 2'd2;
              enableN = 1'b1;
            end else begin
              sB      = 2'd3;
              enableD = 1'b1;
              enableK = 1'b1;
            end
          end else if (r_cnt == C_DIV_LAST) begin
            // Remainder step: A = n against B = d0.
            sA       = 2'd2;
            sB       = 2'd1;
            enableQD = 1'b1;
          end
        end else begin
          if (r_cnt == '0) begin
            enableN = 1'b1;
          end else if (r_cnt == C_ONE) begin
            selBA   = 1'b1;
            enableK = 1'b1;
          end else if (r_cnt == C_TWO) begin
            sA      = 2'd1;
            enableD = 1'b1;
            enableK = 1'b1;
          end else if (r_cnt <= C_SQRT_LOOP_END) begin
            sA = 2'd1;
            if (w_phase == '0) begin
              sB      = 2'd2;
              enableN = 1'b1;
            end else if (w_phase == C_ONE) begin
              selBA   = 1'b1;
              enableK = 1'b1;
            end else begin
              sB      = 2'd3;
              enableD = 1'b1;
              enableK = 1'b1;
            end
          end else if (r_cnt == C_SQRT_LAST) begin
            sA      = 2'd1;
            sB      = 2'd2;
            enableN = 1'b1;
          end
        end
      end

      S_DONE: begin
        // A same-cycle abort cancels the completion report as well as any restart.
        done = !abort;
        if (!abort && start) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
          w_op_nxt    = op;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: doc/goldschmidt_ctrl.md
Name: goldschmidt_ctrl

Overview:
- Unified sequencer for the Goldschmidt divide/square-root datapath. Replaces the free-running divide and square-root counters with a start/done handshake.
- Latches the requested op and drives the operand-mux selects (sA, sB), the explicit B=A square select, and the N/D/K/QD register enables for a parameterised number of iterations.
- Reports completion with a one-cycle done pulse. Sits between the FP unit's issue logic and the datapath.

Parameters:
- DIV_ITERS, 5, number of divide refinement passes; min 1.
- SQRT_ITERS, 4, number of square-root refinement triples; min 1.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request new operation; sampled only in IDLE or DONE
- op  input  2  operation; 00 = divide, any other value = square root; sampled with start
- abort  input  1  synchronous cancel; return to IDLE, no done
- op_q  output  2  latched op, driven to datapath op
- sA  output  2  A-mux select: 0 = k0, 1 = k, 2 = n
- sB  output  2  B-mux select: 0 = n0, 1 = d0, 2 = n, 3 = d
- selBA  output  1  force B operand = A (k·k square step); when 1, sB = 0
- enableN, enableD, enableK, enableQD  output  1 each  datapath register enables
- busy  output  1  high during active cycles
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, reset_n = 0), all outputs at 0:
  - state = IDLE; op_q = 00; sA, sB, selBA, all enables, busy and done = 0.
- States: IDLE -> RUN -> DONE -> IDLE.
  - Step counter cnt is registered, width clog2(max(L_div, L_sqrt)).
  - L_div = 2·DIV_ITERS + 2; L_sqrt = 3·SQRT_ITERS + 4.
- IDLE:
  - All enables 0, sA = sB = 0, selBA = 0, busy = 0.
  - On start: latch op into op_q, set cnt = 0, go to RUN.
- RUN: busy = 1. Outputs are a combinational decode of (op_q, cnt). At the last step go to DONE.
- Divide steps (op_q == 00):
  - cnt 0: sA = 0, sB = 0, enableN.
  - cnt 1: sA = 0, sB = 1, enableD + enableK.
  - cnt 2..2·DIV_ITERS: sA = 1.
    - Even cnt: sB = 2, enableN.
    - Odd cnt: sB = 3, enableD + enableK.
  - cnt 2·DIV_ITERS + 1 (remainder step): sA = 2, sB = 1, enableQD.
- Square-root steps (op_q != 00):
  - cnt 0: sA = 0, sB = 0, enableN.
  - cnt 1: sA = 0, selBA = 1, enableK.
  - cnt 2: sA = 1, sB = 0, enableD + enableK.
  - cnt 3..3·SQRT_ITERS + 2 use phase p = (cnt − 3) mod 3, all with sA = 1:
    - p = 0: sB = 2, enableN.
    - p = 1: selBA = 1, enableK.
    - p = 2: sB = 3, enableD + enableK.
  - cnt 3·SQRT_ITERS + 3: sA = 1, sB = 2, enableN. enableQD is never asserted for square root.
- Exactly one of {sB meaningful, selBA} per step. selBA = 1 only with sA = 0 or 1.
- DONE (one cycle):
  - done = 1, busy = 0, all enables 0.
  - Datapath result and r_sign are valid this cycle and remain valid until the next start.
  - On start: latch new op, cnt = 0, go to RUN (back-to-back issue). Otherwise go to IDLE.
- Latency: start sampled at edge T gives first active step in cycle T+1 and done in cycle T+L+1.
  - Divide: done at T+13 with defaults. Square root: done at T+17 with defaults.
- start while in RUN: ignored. op is not re-latched.
- abort:
  - In RUN: the next state is IDLE. No done pulse, enables 0 from the next cycle.
  - abort has priority over a same-cycle start in IDLE or DONE, and over an in-progress DONE.
  - Datapath registers keep their partial contents.
- reset_n asserted mid-operation: immediate IDLE with reset values. No done pulse.
- op_q is held constant throughout RUN and DONE.
- Any op value other than 00 behaves identically to 01.

Test Plan:
- Divide, defaults: start = 1, op = 00 for one cycle.
  - Required: busy high exactly 12 cycles.
  - Enable sequence N, DK, N, DK, N, DK, N, DK, N, DK, N, QD.
  - Select sequence (sA, sB): (0,0), (0,1), (1,2), (1,3) … (1,2), then (2,1).
  - done is a single pulse 13 cycles after the start edge.
- Square root, defaults: op = 01 with start.
  - Required: 16 active cycles; selBA high at cnt 1, 4, 7, 10, 13.
  - Enables N, K, DK repeated, ending N at cnt 15; enableQD never high.
  - done at T+17.
- Back-to-back: start/op = 00 held; second start/op = 10 in the DONE cycle.
  - Required: done pulse, then the sqrt sequence begins the next cycle with no IDLE gap; op_q = 10.
- Start while busy: pulse start with op = 01 at divide cnt 5.
  - Required: divide sequence unchanged, op_q stays 00, exactly one done.
- Abort: abort at sqrt cnt 7.
  - Required: IDLE next cycle, all enables 0, no done.
  - A following start with op = 00 runs a full 12-step divide.
- Async reset: drop reset_n at divide cnt 4, mid-cycle.
  - Required: outputs go to 0 immediately, without waiting for a clock edge.
  - After release, start is ignored until reset_n = 1 at a clock edge; then a normal 12-step run follows.
